flash_loader: RTL and testbench

Boot-time copier between the SPI NOR flash pins and the RAMIO word-write interface. It issues one standard READ (0x03) command and streams LOAD_BYTES bytes from flash into RAM via RAMIO as 32-bit word writes. It sits beside Core on the shared RAMIO port and owns the flash pins until done. It is clocked from the 20.25 MHz PSRAM user clock.

---
 rtl/flash_loader_pkg.sv | 23 ++
 rtl/flash_loader_if.sv | 18 +
 rtl/flash_spi_shift.sv | 63 ++++++
 rtl/flash_loader.sv | 151 +++++++++++++++
 tb/tb_flash_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI NOR flash boot loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RECV,
    WAIT_RAM,
    WRITE,
    ACK,
    DONE
  } state_t;

  localparam logic [7:0] FLASH_CMD_READ   = 8'h03;
  localparam logic [1:0] RAMIO_WRITE_WORD = 2'b11;
  localparam logic [1:0] RAMIO_WRITE_NONE = 2'b00;

  // Flash bytes arrive first-byte-in-MSB; RAM words are little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] i_word);
    return {i_word[7:0], i_word[15:8], i_word[23:16], i_word[31:24]};
  endfunction

endpackage

// File: rtl/flash_loader_if.sv
// RAMIO word-write port shared between the loader (master) and RAM (slave).
interface flash_loader_if;
  logic        ramio_enable;
  logic [1:0]  ramio_write_type;
  logic [31:0] ramio_address;
  logic [31:0] ramio_data_in;
  logic        ramio_busy;

  modport master (
    output ramio_enable, ramio_write_type, ramio_address, ramio_data_in,
    input  ramio_busy
  );

  modport slave (
    input  ramio_enable, ramio_write_type, ramio_address, ramio_data_in,
    output ramio_busy
  );
endinterface

// File: rtl/flash_spi_shift.sv
// 32-bit SPI mode-0 shift engine: SCK low then high for CLK_DIV clocks per bit,
// MISO sampled and MOSI advanced on the edge that ends each high phase.
module flash_spi_shift #(
  parameter int CLK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_go,
  input  logic [31:0] i_tx,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_done,
  output logic [31:0] o_rx
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             r_active;
  logic             r_phase;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_bit;
  logic [31:0]      r_tx;
  logic [31:0]      r_rx;
  logic             w_tick;

  assign w_tick = r_active && (r_div == DIV_LAST);
  // Asserted in the cycle whose closing edge captures the 32nd bit.
  assign o_done = w_tick && r_phase && (r_bit == 5'd31);
  assign o_sck  = r_phase;
  assign o_mosi = r_tx[31];
  assign o_rx   = r_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= i_tx;
    end else if (r_active) begin
      if (w_tick) begin
        r_div   <= '0;
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_rx  <= {r_rx[30:0], i_miso};
          r_tx  <= {r_tx[30:0], 1'b0};
          r_bit <= r_bit + 5'd1;
          if (r_bit == 5'd31) r_active <= 1'b0;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/flash_loader.sv
// Boot copier: one READ (0x03) from SPI flash, streamed into RAM as 32-bit writes.
// Optional FLASH_LOADER_CHECKSUM_EN adds o_checksum, the mod-2^32 sum of written words.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_START = 24'h000000,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int          LOAD_BYTES  = 4096,
  parameter int          CLK_DIV     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_flash_clk,
  output logic         o_flash_mosi,
  input  logic         i_flash_miso,
  output logic         o_flash_cs,
`ifdef FLASH_LOADER_CHECKSUM_EN
  output logic [31:0]  o_checksum,
`endif
  flash_loader_if.master ramio
);
  localparam int NUM_WORDS = LOAD_BYTES / 4;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_ack_first;
  logic [CNT_W-1:0]  r_words_left;
  logic [31:0]       r_next_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_enable;
  logic [1:0]        r_write_type;
  logic [31:0]       r_address;
  logic [31:0]       r_data;
  logic              w_go;
  logic [31:0]       w_tx;
  logic              w_shift_done;
  logic [31:0]       w_rx;

  flash_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_go    (w_go),
    .i_tx    (w_tx),
    .i_miso  (i_flash_miso),
    .o_sck   (o_flash_clk),
    .o_mosi  (o_flash_mosi),
    .o_done  (w_shift_done),
    .o_rx    (w_rx)
  );

  always_comb begin
    w_state_next = r_state;
    w_go         = 1'b0;
    w_tx         = '0;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_next = CMD;
        w_go         = 1'b1;
        w_tx         = {FLASH_CMD_READ, FLASH_START};
      end
      CMD: if (w_shift_done) begin
        w_state_next = RECV;
        w_go         = 1'b1;
      end
      RECV:     if (w_shift_done) w_state_next = WAIT_RAM;
      WAIT_RAM: if (!ramio.ramio_busy) w_state_next = WRITE;
      WRITE:    w_state_next = ACK;
      // First ACK cycle ignores busy so RAMIO has time to raise it.
      ACK: if (!r_ack_first && !ramio.ramio_busy) begin
        if (r_words_left != '0) begin
          w_state_next = RECV;
          w_go         = 1'b1;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ack_first  <= 1'b0;
      r_words_left <= '0;
      r_next_addr  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cs         <= 1'b1;
      r_enable     <= 1'b0;
      r_write_type <= RAMIO_WRITE_NONE;
      r_address    <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ack_first  <= (r_state == WRITE);
      r_enable     <= (w_state_next == WRITE);
      r_write_type <= (w_state_next inside {WRITE, ACK}) ? RAMIO_WRITE_WORD : RAMIO_WRITE_NONE;
      r_cs         <= !(w_state_next inside {CMD, RECV, WAIT_RAM, WRITE, ACK});
      if (r_state == IDLE && i_start) begin
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_words_left <= CNT_W'(NUM_WORDS);
        r_next_addr  <= RAM_BASE;
      end
      if (w_state_next == DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (r_state == WAIT_RAM && w_state_next == WRITE) begin
        r_address <= r_next_addr;
        r_data    <= byte_swap32(w_rx);
      end
      if (r_state == WRITE) begin
        r_next_addr  <= r_next_addr + 32'd4;
        r_words_left <= r_words_left - CNT_W'(1);
      end
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_checksum <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

  assign o_busy                 = r_busy;
  assign o_done                 = r_done;
  assign o_flash_cs             = r_cs;
  assign ramio.ramio_enable     = r_enable;
  assign ramio.ramio_write_type = r_write_type;
  assign ramio.ramio_address    = r_address;
  assign ramio.ramio_data_in    = r_data;
endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: flash model, RAMIO busy model and write scoreboard.
// Checksum comparisons are compiled only with FLASH_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_flash_loader;
  import flash_loader_pkg::*;

  localparam int LB  = 8;
  localparam int CD  = 3;
  localparam int NW  = LB / 4;
  localparam int LAT = 128 * CD + 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] fbytes;   // first flash byte in [63:56]
    int          wait_stall;
    int          ack_stall;
    bit          mid_start;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic [31:0] exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flash_miso = 1'b0;
  logic busy, done, flash_clk, flash_mosi, flash_cs;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  flash_loader_if ramio ();

  flash_loader #(
    .FLASH_START (24'h000000),
    .RAM_BASE    (32'h0000_0000),
    .LOAD_BYTES  (LB),
    .CLK_DIV     (CD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_flash_clk  (flash_clk),
    .o_flash_mosi (flash_mosi),
    .i_flash_miso (flash_miso),
    .o_flash_cs   (flash_cs),
`ifdef FLASH_LOADER_CHECKSUM_EN
    .o_checksum   (checksum),
`endif
    .ramio        (ramio)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  logic [7:0] flash_mem [8];
  logic [31:0] cmd_sr = '0;
  int fbits = 0;
  int wait_stall = 0;
  int ack_stall = 0;
  int busy_cnt = 0;
  bit lat_check = 1'b0;
  int t0 = 0;
  int writes_seen = 0;
  int done_rises = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic [31:0] prev_addr = '0;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAMIO busy model: busy stays high while busy_cnt drains.
  initial begin
    ramio.ramio_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        ramio.ramio_busy = 1'b1;
        busy_cnt--;
      end else begin
        ramio.ramio_busy = 1'b0;
      end
    end
  end

  // Flash model: capture the command on SCK rise, present data on SCK fall.
  initial begin
    forever begin
      @(posedge flash_clk or posedge flash_cs);
      if (flash_cs) begin
        fbits = 0;
      end else begin
        if (fbits < 32) cmd_sr = {cmd_sr[30:0], flash_mosi};
        fbits++;
      end
    end
  end

  initial begin
    int j;
    forever begin
      @(negedge flash_clk);
      if (!flash_cs && fbits >= 32) begin
        j = fbits - 32;
        flash_miso = flash_mem[(int'(cmd_sr[23:0]) + j / 8) % 8][7 - (j % 8)];
        if (j > 0 && (j % 32) == 0) busy_cnt = wait_stall;
      end
    end
  end

  // Scoreboard: every RAMIO strobe pops one expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ramio.ramio_enable) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: got addr %08h data %08h, required no write",
                     ramio.ramio_address, ramio.ramio_data_in);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", ramio.ramio_address, e.addr);
            check("wr_data", ramio.ramio_data_in, e.data);
            check("wr_type", ramio.ramio_write_type, RAMIO_WRITE_WORD);
          end
          check("en_after_busy_low", prev_busy, 1'b0);
          if (lat_check && writes_seen == 1) check("first_write_latency", cyc - t0, LAT);
          busy_cnt = ack_stall;
          $display("[TB] write #%0d addr=%08h data=%08h cyc=%0d", writes_seen,
                   ramio.ramio_address, ramio.ramio_data_in, cyc);
        end
        if (prev_en) begin
          check("enable_one_cycle", ramio.ramio_enable, 1'b0);
          check("ack_type_hold", ramio.ramio_write_type, RAMIO_WRITE_WORD);
          check("ack_addr_hold", ramio.ramio_address, prev_addr);
        end
        if (done && !prev_done) done_rises++;
      end
      prev_en   = rst_n && ramio.ramio_enable;
      prev_addr = ramio.ramio_address;
      prev_busy = ramio.ramio_busy;
      prev_done = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int waited;
    for (int i = 0; i < 8; i++) flash_mem[i] = v.fbytes[63 - 8 * i -: 8];
    wait_stall = v.wait_stall;
    ack_stall = v.ack_stall;
    lat_check = (v.wait_stall == 0);
    exp_q.push_back(wr_t'{32'h0000_0000, v.exp_w0});
    exp_q.push_back(wr_t'{32'h0000_0004, v.exp_w1});
    writes_seen = 0;
    done_rises = 0;
    pulse_start();
    check($sformatf("v%0d_busy_after_start", idx), busy, 1'b1);
    check($sformatf("v%0d_done_cleared", idx), done, 1'b0);
    if (v.mid_start) begin
      repeat (150) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (!done && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("v%0d_done", idx), done, 1'b1);
    check($sformatf("v%0d_cs_at_done", idx), flash_cs, 1'b1);
    check($sformatf("v%0d_busy_at_done", idx), busy, 1'b0);
    check($sformatf("v%0d_write_count", idx), writes_seen, NW);
    check($sformatf("v%0d_mosi_cmd", idx), cmd_sr, 32'h0300_0000);
`ifdef FLASH_LOADER_CHECKSUM_EN
    check($sformatf("v%0d_checksum", idx), checksum, v.exp_sum);
`endif
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_done_held", idx), done, 1'b1);
    check($sformatf("v%0d_done_rises", idx), done_rises, 1);
    check($sformatf("v%0d_idle_type", idx), ramio.ramio_write_type, RAMIO_WRITE_NONE);
    check($sformatf("v%0d_sclk_idle", idx), flash_clk, 1'b0);
    check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{64'h1122_3344_5566_7788, 0, 0, 1'b0, 32'h4433_2211, 32'h8877_6655, 32'hCCAA_8866};
    vecs[1] = '{64'h1122_3344_5566_7788, 20, 5, 1'b0, 32'h4433_2211, 32'h8877_6655, 32'hCCAA_8866};
    vecs[2] = '{64'hFFFF_FFFF_0200_0000, 0, 0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[3] = '{64'hDEAD_BEEF_0180_7F00, 2, 1, 1'b1, 32'hEFBE_ADDE, 32'h007F_8001, 32'hF03E_2DDF};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sclk", flash_clk, 1'b0);
    check("rst_mosi", flash_mosi, 1'b0);
    check("rst_cs", flash_cs, 1'b1);
    check("rst_enable", ramio.ramio_enable, 1'b0);
    check("rst_type", ramio.ramio_write_type, RAMIO_WRITE_NONE);
    check("rst_addr", ramio.ramio_address, 32'h0);
    check("rst_data", ramio.ramio_data_in, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_load(vecs[i], i);

    // Reset during the 10th data bit of the first word: no write may escape.
    for (int i = 0; i < 8; i++) flash_mem[i] = vecs[0].fbytes[63 - 8 * i -: 8];
    wait_stall = 0;
    ack_stall = 0;
    lat_check = 1'b0;
    writes_seen = 0;
    pulse_start();
    waited = 0;
    while (fbits != 42 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_reached_bit", fbits, 42);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", flash_cs, 1'b1);
    check("rst_mid_enable", ramio.ramio_enable, 1'b0);
    check("rst_mid_sclk", flash_clk, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_write", writes_seen, 0);
    check("rst_mid_done", done, 1'b0);
    run_load(vecs[0], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
